// File: rtl/csmult_pipelined.sv
// rtl/csmult_pipelined.sv - pipelined carry-save array multiplier with valid/ready full-pipeline stall
// Define CSMULT_SIGNED_EN to add the in_signed port and Baugh-Wooley two's-complement mode.
module csmult_pipelined #(
    parameter int BITSIZE     = 8,
    parameter int PIPE_STAGES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BITSIZE-1:0]     factor0,
    input  logic [BITSIZE-1:0]     factor1,
`ifdef CSMULT_SIGNED_EN
    input  logic                   in_signed,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*BITSIZE-1:0]   product
);
    localparam int ROWS_PER_STAGE = (BITSIZE + PIPE_STAGES - 1) / PIPE_STAGES;
`ifdef CSMULT_SIGNED_EN
    localparam logic [BITSIZE-1:0] BW_CORR = BITSIZE'((1 << (BITSIZE - 1)) | 1);
`endif

    // s[j] carries weight 2^(row+j), c[j] weight 2^(row+j+1); lo collects finished low bits.
    typedef struct packed {
        logic               vld;
`ifdef CSMULT_SIGNED_EN
        logic               sgn;
`endif
        logic [BITSIZE-1:0] f0, f1, s, c, lo;
    } stage_t;

    stage_t               stg_src [PIPE_STAGES];
    stage_t               stg_d   [PIPE_STAGES];
    stage_t               stg_q   [PIPE_STAGES];
    logic                 stall;
    logic                 accept;
    logic                 out_valid_q;
    logic [2*BITSIZE-1:0] product_q;
    logic [2*BITSIZE-1:0] product_d;
    logic [BITSIZE-1:0]   hi_d;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign product   = product_q;

    always_comb begin
        stg_src[0]     = '0;
        stg_src[0].vld = accept;
        stg_src[0].f0  = factor0;
        stg_src[0].f1  = factor1;
`ifdef CSMULT_SIGNED_EN
        stg_src[0].sgn = in_signed;
`endif
        for (int g = 1; g < PIPE_STAGES; g++) begin
            stg_src[g] = stg_q[g-1];
        end
    end

    always_comb begin : row_logic
        stage_t             cur;
        logic [BITSIZE-1:0] pp;
        logic [BITSIZE-1:0] s_sh;
        logic [BITSIZE-1:0] ns;
        logic [BITSIZE-1:0] nc;
        cur  = '0;
        pp   = '0;
        s_sh = '0;
        ns   = '0;
        nc   = '0;
        for (int g = 0; g < PIPE_STAGES; g++) begin
            cur = stg_src[g];
            for (int r = 0; r < BITSIZE; r++) begin
                if (r >= g * ROWS_PER_STAGE && r < (g + 1) * ROWS_PER_STAGE) begin
                    pp = {BITSIZE{cur.f0[r]}} & cur.f1;
`ifdef CSMULT_SIGNED_EN
                    // Invert terms where exactly one operand bit is a sign bit.
                    if (cur.sgn) begin
                        if (r == BITSIZE - 1) pp[BITSIZE-2:0] = ~pp[BITSIZE-2:0];
                        else                  pp[BITSIZE-1]   = ~pp[BITSIZE-1];
                    end
`endif
                    s_sh      = cur.s >> 1;
                    ns        = pp ^ s_sh ^ cur.c;
                    nc        = (pp & s_sh) | (pp & cur.c) | (s_sh & cur.c);
                    cur.s     = ns;
                    cur.c     = nc;
                    cur.lo[r] = ns[0];
                end
            end
            stg_d[g] = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < PIPE_STAGES; g++) begin
                stg_q[g].vld <= 1'b0;
            end
        end else if (!stall) begin
            for (int g = 0; g < PIPE_STAGES; g++) begin
                stg_q[g] <= stg_d[g];
            end
        end
    end

    always_comb begin
        hi_d = (stg_q[PIPE_STAGES-1].s >> 1) + stg_q[PIPE_STAGES-1].c;
`ifdef CSMULT_SIGNED_EN
        if (stg_q[PIPE_STAGES-1].sgn) hi_d = hi_d + BW_CORR;
`endif
        product_d = {hi_d, stg_q[PIPE_STAGES-1].lo};
    end

    // Bubbles leave product untouched so the last real result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= stg_q[PIPE_STAGES-1].vld;
            if (stg_q[PIPE_STAGES-1].vld) product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_csmult_pipelined.sv
// tb/tb_csmult_pipelined.sv - directed self-checking bench for csmult_pipelined
module tb_csmult_pipelined;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  factor0;
    logic [7:0]  factor1;
`ifdef CSMULT_SIGNED_EN
    logic        in_signed;
`endif
    logic        in_ready;
    logic        out_valid;
    logic [15:0] product;
    logic        rdy1, ov1, rdy3, ov3, rdy8, ov8, rdy5, ov5;
    logic [15:0] prod1, prod3, prod8;
    logic [9:0]  prod5;
    int          n_pass = 0;
    int          n_total = 0;

    csmult_pipelined dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .factor0(factor0), .factor1(factor1),
`ifdef CSMULT_SIGNED_EN
        .in_signed(in_signed),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    csmult_pipelined #(.BITSIZE(8), .PIPE_STAGES(1)) u_ps1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .factor0(factor0), .factor1(factor1),
`ifdef CSMULT_SIGNED_EN
        .in_signed(in_signed),
`endif
        .out_valid(ov1), .out_ready(out_ready), .product(prod1)
    );

    csmult_pipelined #(.BITSIZE(8), .PIPE_STAGES(3)) u_ps3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
        .factor0(factor0), .factor1(factor1),
`ifdef CSMULT_SIGNED_EN
        .in_signed(in_signed),
`endif
        .out_valid(ov3), .out_ready(out_ready), .product(prod3)
    );

    csmult_pipelined #(.BITSIZE(8), .PIPE_STAGES(8)) u_ps8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .factor0(factor0), .factor1(factor1),
`ifdef CSMULT_SIGNED_EN
        .in_signed(in_signed),
`endif
        .out_valid(ov8), .out_ready(out_ready), .product(prod8)
    );

    csmult_pipelined #(.BITSIZE(5), .PIPE_STAGES(2)) u_b5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5),
        .factor0(factor0[4:0]), .factor1(factor1[4:0]),
`ifdef CSMULT_SIGNED_EN
        .in_signed(in_signed),
`endif
        .out_valid(ov5), .out_ready(out_ready), .product(prod5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One operand pair into an idle pipeline; lat counts edges from the accept edge (0 = timeout).
    task automatic run_one(input logic [7:0] a, input logic [7:0] b, output int lat, output logic [15:0] p);
        in_valid = 1'b1;
        factor0  = a;
        factor1  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        p   = '0;
        for (int n = 1; n <= 20; n++) begin
            if (out_valid) begin
                lat = n;
                p   = product;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (product !== 16'h0000) $display("FAIL reset_product got %h exp 0000", product); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_latency();
        int          lat;
        logic [15:0] p;
        out_ready = 1'b1;
        run_one(8'hFF, 8'hFF, lat, p);
        n_total++; if (lat !== 5) $display("FAIL latency_cycles got %0d exp 5", lat); else n_pass++;
        n_total++; if (p !== 16'hFE01) $display("FAIL latency_product got %h exp fe01", p); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL latency_bubble got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] ve [3];
        int          w;
        va = '{8'h00, 8'h0F, 8'h80};
        vb = '{8'h5A, 8'h11, 8'h02};
        ve = '{16'h0000, 16'h00FF, 16'h0100};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            factor0  = va[k];
            factor1  = vb[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        for (int k = 0; k < 3; k++) begin
            n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid%0d got %b exp 1", k, out_valid); else n_pass++;
            n_total++; if (product !== ve[k]) $display("FAIL b2b_product%0d got %h exp %h", k, product, ve[k]); else n_pass++;
            @(posedge clk); #1;
        end
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0]  va [7];
        logic [7:0]  vb [7];
        logic [15:0] ve [7];
        int          idx, nout, stall_n, first_c, last_c;
        logic        acc, hs;
        va = '{8'h03, 8'h10, 8'hA5, 8'hFF, 8'h0C, 8'h7E, 8'h22};
        vb = '{8'h07, 8'h10, 8'h02, 8'h01, 8'h0D, 8'h03, 8'h44};
        ve = '{16'h0015, 16'h0100, 16'h014A, 16'h00FF, 16'h009C, 16'h017A, 16'h0908};
        idx = 0; nout = 0; stall_n = 0; first_c = -1; last_c = -1;
        out_ready = 1'b0;
        for (int c = 0; c < 60 && nout < 7; c++) begin
            if (stall_n >= 6) out_ready = 1'b1;
            in_valid = (idx < 7);
            if (idx < 7) begin
                factor0 = va[idx];
                factor1 = vb[idx];
            end
            #1;
            if (!out_ready && out_valid) begin
                if (stall_n == 0) begin
                    n_total++; if (idx !== 5) $display("FAIL stall_fill got %0d exp 5", idx); else n_pass++;
                end
                n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b exp 0", in_ready); else n_pass++;
                n_total++; if (product !== ve[0]) $display("FAIL stall_hold got %h exp %h", product, ve[0]); else n_pass++;
                stall_n++;
            end
            acc = in_valid & in_ready;
            hs  = out_valid & out_ready;
            if (hs) begin
                n_total++; if (product !== ve[nout]) $display("FAIL stall_drain%0d got %h exp %h", nout, product, ve[nout]); else n_pass++;
                if (first_c < 0) first_c = c;
                last_c = c;
                nout++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_total++; if (nout !== 7) $display("FAIL stall_count got %0d exp 7", nout); else n_pass++;
        n_total++; if (last_c - first_c !== 6) $display("FAIL stall_rate got %0d exp 6", last_c - first_c); else n_pass++;
        n_total++; if (stall_n !== 6) $display("FAIL stall_cycles got %0d exp 6", stall_n); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [7:0]  a, b;
        int          lat [4];
        logic [15:0] pr [3];
        logic [9:0]  p5;
        logic [15:0] e16;
        logic [9:0]  e10;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        for (int t = 0; t < 4; t++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (t == 0) begin
                a = 8'hFF;
                b = 8'hFF;
            end
            e16 = {8'h00, a} * {8'h00, b};
            e10 = {5'h00, a[4:0]} * {5'h00, b[4:0]};
            in_valid = 1'b1;
            factor0  = a;
            factor1  = b;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = '{default: 0};
            pr  = '{default: 16'h0};
            p5  = '0;
            for (int n = 1; n <= 14; n++) begin
                if (ov1 && lat[0] == 0) begin lat[0] = n; pr[0] = prod1; end
                if (ov3 && lat[1] == 0) begin lat[1] = n; pr[1] = prod3; end
                if (ov8 && lat[2] == 0) begin lat[2] = n; pr[2] = prod8; end
                if (ov5 && lat[3] == 0) begin lat[3] = n; p5 = prod5; end
                @(posedge clk); #1;
            end
            n_total++; if (lat[0] !== 2) $display("FAIL sweep_ps1_lat got %0d exp 2", lat[0]); else n_pass++;
            n_total++; if (pr[0] !== e16) $display("FAIL sweep_ps1_prod got %h exp %h", pr[0], e16); else n_pass++;
            n_total++; if (lat[1] !== 4) $display("FAIL sweep_ps3_lat got %0d exp 4", lat[1]); else n_pass++;
            n_total++; if (pr[1] !== e16) $display("FAIL sweep_ps3_prod got %h exp %h", pr[1], e16); else n_pass++;
            n_total++; if (lat[2] !== 9) $display("FAIL sweep_ps8_lat got %0d exp 9", lat[2]); else n_pass++;
            n_total++; if (pr[2] !== e16) $display("FAIL sweep_ps8_prod got %h exp %h", pr[2], e16); else n_pass++;
            n_total++; if (lat[3] !== 3) $display("FAIL sweep_b5_lat got %0d exp 3", lat[3]); else n_pass++;
            n_total++; if (p5 !== e10) $display("FAIL sweep_b5_prod got %h exp %h", p5, e10); else n_pass++;
        end
    endtask

    task automatic test_midflight_reset();
        int          stale, lat;
        logic [15:0] p;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            factor0  = 8'h11 + 8'(k);
            factor1  = 8'h0F;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (product !== 16'h0000) $display("FAIL midrst_product got %h exp 0000", product); else n_pass++;
        stale = 0;
        repeat (12) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        n_total++; if (stale !== 0) $display("FAIL midrst_stale got %0d exp 0", stale); else n_pass++;
        run_one(8'h03, 8'h05, lat, p);
        n_total++; if (lat !== 5) $display("FAIL midrst_new_lat got %0d exp 5", lat); else n_pass++;
        n_total++; if (p !== 16'h000F) $display("FAIL midrst_new_prod got %h exp 000f", p); else n_pass++;
        @(posedge clk); #1;
    endtask

`ifdef CSMULT_SIGNED_EN
    task automatic test_signed();
        logic [7:0]  sa [5];
        logic [7:0]  sb [5];
        logic        sm [5];
        logic [15:0] se [5];
        int          lat;
        logic [15:0] p;
        sa = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'hFF};
        sb = '{8'h80, 8'h01, 8'h80, 8'h80, 8'h01};
        sm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        se = '{16'h4000, 16'hFFFF, 16'hC080, 16'h4000, 16'h00FF};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_signed = sm[k];
            run_one(sa[k], sb[k], lat, p);
            n_total++; if (lat !== 5) $display("FAIL signed_lat%0d got %0d exp 5", k, lat); else n_pass++;
            n_total++; if (p !== se[k]) $display("FAIL signed_prod%0d got %h exp %h", k, p, se[k]); else n_pass++;
            @(posedge clk); #1;
        end
        in_signed = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        factor0   = '0;
        factor1   = '0;
`ifdef CSMULT_SIGNED_EN
        in_signed = 1'b0;
`endif
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_sweep();
        test_midflight_reset();
`ifdef CSMULT_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
